// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with RAW busy scoreboard
// Optional same-cycle write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_index,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_index,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic                     stall
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wb_hit;
  logic              issue_hit;

  // Index 0 is hard-wired: writes and issues to it are dropped here.
  assign wb_hit    = wb_en && (wb_index != '0);
  assign issue_hit = issue_en && (issue_rd != '0);

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_next = busy;
    if (wb_hit)    busy_next[wb_index] = 1'b0;
    if (issue_hit) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wb_hit) regs[wb_index] <= wb_data;
      busy <= busy_next;
    end
  end

  // Outputs are gated by rst_n so nothing (including a forwarded write) leaks during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rst_n && (rd_index[p*ADDR_W +: ADDR_W] != '0)) begin
        rd_data[p*DATA_W +: DATA_W] = regs[rd_index[p*ADDR_W +: ADDR_W]];
        rd_busy[p]                  = busy[rd_index[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (rd_index[p*ADDR_W +: ADDR_W] == wb_index)) begin
          rd_data[p*DATA_W +: DATA_W] = wb_data;
          rd_busy[p]                  = 1'b0;
        end
`endif
      end
    end
  end

  assign stall = |rd_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the core's 32x32 register file. Provides NUM_RD combinational read ports, one synchronous write-back port, an asynchronous clear of all registers, and a hard-wired zero register 0. Adds a per-register busy scoreboard (set at issue, cleared at write-back) so the decode stage can detect RAW hazards and stall. Sits between decode (read/issue side) and write-back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, index width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_en  in  1  write-back enable
wb_index  in  ADDR_W  write-back destination index
wb_data  in  DATA_W  write-back data
rd_index  in  NUM_RD*ADDR_W  read indices, port p at bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port p at bits [p*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port p's source register has a pending write
issue_en  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  ADDR_W  destination index of the issued instruction
stall  out  1  OR of rd_busy over all ports

Behaviour:
- Reset (rst_n=0, asynchronous): all registers and all busy bits clear to 0. While in reset, rd_data=0, rd_busy=0, stall=0. Takes effect immediately, including mid-write and mid-issue; the first rising edge after deassertion behaves normally.
- Write: on a rising edge with wb_en=1 and wb_index!=0, regs[wb_index] <= wb_data. With wb_en=0 no register changes. A write to index 0 is discarded; register 0 always reads 0 and is never busy.
- Read: combinational. rd_data[p] = regs[rd_index[p]]; index 0 returns 0. Ports are independent, and any number of ports may address the same index.
- Scoreboard: busy[i] is one bit per register, updated on the rising edge.
  - Set: issue_en=1 and issue_rd!=0 sets busy[issue_rd].
  - Clear: wb_en=1 and wb_index!=0 clears busy[wb_index].
  - Same edge, same index (issue and write-back together): set wins, so busy stays 1 for the new producer, and the register data is still updated.
  - Same edge, different indices: both updates apply.
  - Write-back to a non-busy register: data is written, busy stays 0, and this is not an error.
  - Issue to an already-busy register: busy stays 1 (WAW). A single write-back clears it; ordering is the pipeline's responsibility.
- rd_busy[p] = busy[rd_index[p]], combinational, and is 0 for index 0. stall = |rd_busy.
- Latency: write visible on rd_data one cycle after the edge that captures it, unless REGFILE_BYPASS_EN is defined. Busy set or clear is visible on the cycle after the edge.
- Width rules: no truncation or extension. All indices are exactly ADDR_W bits, covering the whole depth.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: same-cycle write-to-read forwarding. If wb_en=1, wb_index!=0 and rd_index[p]==wb_index, then rd_data[p]=wb_data and rd_busy[p]=0 in that same cycle (combinational from wb_*).
  - If issue_en targets the same index in that cycle, rd_busy[p] is still 0 this cycle and becomes 1 next cycle.
- Undefined: no forwarding. Reads return the stored value and rd_busy reflects stored busy only. The same-cycle write is visible on the next cycle.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, assert rst_n=0 between clock edges -> rd_data for r5 reads 0 immediately; after release, r5 still reads 0 and stall=0.
- Zero register: wb_en=1, wb_index=0, wb_data=0xFFFFFFFF; issue_en=1, issue_rd=0 -> port reading r0 returns 0, rd_busy=0.
- Multi-port read: r3=0x11, r7=0x22, NUM_RD=2, ports on r3/r7 -> 0x11/0x22; both ports on r7 -> 0x22/0x22.
- Scoreboard lifecycle: issue r9 at edge N -> rd_busy=1 and stall=1 for port reading r9 from N+1; write-back r9=0x1234 at edge N+3 -> from N+4 busy=0 and data=0x1234.
- Simultaneous issue and write-back on r4 (previously busy) -> data updates to new value and busy remains 1; a later single write-back clears it.
- Bypass: write-back r12=0xCAFE while port 0 reads r12 -> with REGFILE_BYPASS_EN, 0xCAFE and rd_busy=0 in the same cycle; without it, old value this cycle and 0xCAFE next cycle.
